// File: rtl/time_count24.sv
// BCD hh:mm:ss counter for a 24-hour clock with hour/minute set modes and blink flags.
// All outputs are registered; time advances on the 1 Hz ENABLE tick while in RUN.
module time_count24 #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00,
  parameter logic [7:0] INIT_SEC  = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       EN05,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [7:0] SEC_BCD,
  output logic [7:0] MIN_BCD,
  output logic [7:0] HOUR_BCD,
  output logic [1:0] MODE,
  output logic       BLANK_HOUR,
  output logic       BLANK_MIN,
  output logic       DAY_CARRY
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10,
    StBad     = 2'b11
  } mode_e;

  mode_e      mode_q, mode_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       blank_hour_q, blank_hour_d;
  logic       blank_min_q, blank_min_d;
  logic       day_carry_q, day_carry_d;

  // Returns {wrapped, next}. Any code at or past 'last' (or a stray units digit >= 9)
  // is steered back into the legal BCD range so outputs never show non-BCD codes.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [8:0] r;
    if (v >= last) begin
      r = {1'b1, 8'h00};
    end else if (v[3:0] >= 4'd9) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [8:0] sec_inc, min_inc, hour_inc;

  always_comb begin
    sec_inc  = bcd_inc(sec_q, 8'h59);
    min_inc  = bcd_inc(min_q, 8'h59);
    hour_inc = bcd_inc(hour_q, 8'h23);
  end

  // Mode sequencing; the unused code falls back to RUN.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      StRun:     if (BTN_MODE) mode_d = StSetHour;
      StSetHour: if (BTN_MODE) mode_d = StSetMin;
      StSetMin:  if (BTN_MODE) mode_d = StRun;
      default:   mode_d = StRun;
    endcase
  end

  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_carry_d = 1'b0;
    unique case (mode_q)
      StRun: begin
        if (ENABLE) begin
          sec_d = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_d = min_inc[7:0];
            if (min_inc[8]) begin
              hour_d      = hour_inc[7:0];
              day_carry_d = hour_inc[8];
            end
          end
        end
      end
      StSetHour: begin
        if (BTN_UP && !BTN_MODE) hour_d = hour_inc[7:0];
      end
      StSetMin: begin
        if (BTN_UP && !BTN_MODE) min_d = min_inc[7:0];
        // Returning to RUN restarts the minute from zero seconds.
        if (BTN_MODE) sec_d = 8'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    blank_hour_d = (mode_d == StSetHour) && !EN05;
    blank_min_d  = (mode_d == StSetMin) && !EN05;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q       <= StRun;
      sec_q        <= INIT_SEC;
      min_q        <= INIT_MIN;
      hour_q       <= INIT_HOUR;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
      day_carry_q  <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      blank_hour_q <= blank_hour_d;
      blank_min_q  <= blank_min_d;
      day_carry_q  <= day_carry_d;
    end
  end

  assign SEC_BCD    = sec_q;
  assign MIN_BCD    = min_q;
  assign HOUR_BCD   = hour_q;
  assign MODE       = mode_q;
  assign BLANK_HOUR = blank_hour_q;
  assign BLANK_MIN  = blank_min_q;
  assign DAY_CARRY  = day_carry_q;

endmodule

// File: tb/tb_time_count24.sv
// Randomised and directed bench for time_count24: two instances (default and 23:59:58 preload)
// share stimulus and are each compared every cycle against an integer-arithmetic clock model.
module tb_time_count24;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, en05, btn_mode, btn_up;

  logic [7:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;
  logic [1:0] mode_a, mode_b;
  logic       bh_a, bm_a, dc_a, bh_b, bm_b, dc_b;

  always #4 clk = ~clk;

  time_count24 u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .EN05(en05),
    .BTN_MODE(btn_mode), .BTN_UP(btn_up),
    .SEC_BCD(sec_a), .MIN_BCD(min_a), .HOUR_BCD(hour_a), .MODE(mode_a),
    .BLANK_HOUR(bh_a), .BLANK_MIN(bm_a), .DAY_CARRY(dc_a)
  );

  time_count24 #(
    .INIT_HOUR(8'h23), .INIT_MIN(8'h59), .INIT_SEC(8'h58)
  ) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .EN05(en05),
    .BTN_MODE(btn_mode), .BTN_UP(btn_up),
    .SEC_BCD(sec_b), .MIN_BCD(min_b), .HOUR_BCD(hour_b), .MODE(mode_b),
    .BLANK_HOUR(bh_b), .BLANK_MIN(bm_b), .DAY_CARRY(dc_b)
  );

  int total = 0;
  int bad = 0;

  // Reference model: plain integers, mode 0=run 1=set hour 2=set minute.
  int init_h[2] = '{0, 23};
  int init_m[2] = '{0, 59};
  int init_s[2] = '{0, 58};
  int mh[2], mm[2], ms[2], mmode[2];
  bit mbh[2], mbm[2], mdc[2];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = init_h[i]; mm[i] = init_m[i]; ms[i] = init_s[i];
      mmode[i] = 0; mbh[i] = 0; mbm[i] = 0; mdc[i] = 0;
    end
  endtask

  task automatic model_step(input bit ena, input bit e05, input bit bmode, input bit bup);
    for (int i = 0; i < 2; i++) begin
      mdc[i] = 0;
      if (mmode[i] == 0 && ena) begin
        ms[i]++;
        if (ms[i] == 60) begin
          ms[i] = 0; mm[i]++;
          if (mm[i] == 60) begin
            mm[i] = 0; mh[i]++;
            if (mh[i] == 24) begin mh[i] = 0; mdc[i] = 1; end
          end
        end
      end
      if (bup && !bmode && mmode[i] == 1) mh[i] = (mh[i] + 1) % 24;
      if (bup && !bmode && mmode[i] == 2) mm[i] = (mm[i] + 1) % 60;
      if (bmode) begin
        if (mmode[i] == 2) ms[i] = 0;
        mmode[i] = (mmode[i] + 1) % 3;
      end
      mbh[i] = (mmode[i] == 1) && !e05;
      mbm[i] = (mmode[i] == 2) && !e05;
    end
  endtask

  task automatic check_dut(input int i, input string p, input logic [7:0] s, input logic [7:0] mi,
                           input logic [7:0] h, input logic [1:0] md, input logic bh,
                           input logic bmn, input logic dc);
    check_val({p, "sec"}, 32'(s), 32'(to_bcd(ms[i])));
    check_val({p, "min"}, 32'(mi), 32'(to_bcd(mm[i])));
    check_val({p, "hour"}, 32'(h), 32'(to_bcd(mh[i])));
    check_val({p, "mode"}, 32'(md), 32'(mmode[i]));
    check_val({p, "blank_hour"}, 32'(bh), 32'(mbh[i]));
    check_val({p, "blank_min"}, 32'(bmn), 32'(mbm[i]));
    check_val({p, "day_carry"}, 32'(dc), 32'(mdc[i]));
  endtask

  task automatic check_all();
    check_dut(0, "a_", sec_a, min_a, hour_a, mode_a, bh_a, bm_a, dc_a);
    check_dut(1, "b_", sec_b, min_b, hour_b, mode_b, bh_b, bm_b, dc_b);
  endtask

  // Called at a negedge: drive, take one rising edge, update the model, compare, realign.
  task automatic cycle(input bit ena, input bit bmode, input bit bup);
    bit e05;
    enable = ena; btn_mode = bmode; btn_up = bup;
    if ($urandom_range(0, 3) == 0) en05 = ~en05;
    e05 = en05;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(ena, e05, bmode, bup);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; en05 = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check_val("rst_a_time", 32'({hour_a, min_a, sec_a}), 32'h000000);
    check_val("rst_b_time", 32'({hour_b, min_b, sec_b}), 32'h235958);
    rst_n = 1'b1;

    // Tick spacing of 10 cycles; b rolls over the day on the second tick.
    cycle(1, 0, 0);
    check_val("b_235959", 32'({hour_b, min_b, sec_b}), 32'h235959);
    repeat (9) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_val("b_rollover", 32'({hour_b, min_b, sec_b}), 32'h000000);
    check_val("b_carry_hi", 32'(dc_b), 32'd1);
    cycle(0, 0, 0);
    check_val("b_carry_lo", 32'(dc_b), 32'd0);
    repeat (8) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_val("a_sec_03", 32'({hour_a, min_a, sec_a}), 32'h000003);
    repeat (4) cycle(0, 0, 0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_val("async_rst_a", 32'({hour_a, min_a, sec_a}), 32'h000000);
    check_val("async_rst_b", 32'({hour_b, min_b, sec_b}), 32'h235958);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0);
    check_val("a_first_tick", 32'(sec_a), 32'h01);

    // Hour set with back-to-back increments; ticks ignored while setting.
    cycle(0, 1, 0);
    repeat (25) cycle(0, 0, 1);
    check_val("a_hour_01", 32'(hour_a), 32'h01);
    repeat (3) cycle(1, 0, 0);
    check_val("a_sec_frozen", 32'(sec_a), 32'h01);
    check_val("a_min_kept", 32'(min_a), 32'h00);
    check_val("a_blank_min_0", 32'(bm_a), 32'd0);
    cycle(0, 1, 1);
    check_val("mode_wins_mode", 32'(mode_a), 32'd2);
    check_val("mode_wins_hour", 32'(hour_a), 32'h01);

    // Minute 59 -> 00 without carry, then leaving set mode clears seconds.
    cycle(0, 1, 0);
    repeat (37) cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    repeat (59) cycle(0, 0, 1);
    check_val("a_min59_sec37", 32'({min_a, sec_a}), 32'h5937);
    cycle(0, 0, 1);
    check_val("a_min_wrap", 32'({hour_a, min_a}), 32'h0100);
    cycle(0, 1, 0);
    check_val("a_exit_set", 32'({mode_a, sec_a}), 32'h000);
    check_val("a_exit_blank", 32'({bh_a, bm_a}), 32'd0);

    // Tick and mode press together in RUN.
    repeat (5) cycle(1, 0, 0);
    check_val("a_sec_05", 32'(sec_a), 32'h05);
    cycle(1, 1, 0);
    check_val("tick_mode", 32'({mode_a, sec_a}), 32'h106);

    // Walk to 12:09:59 and check the BCD tens carry.
    n = (12 - mh[0] + 24) % 24;
    repeat (n) cycle(0, 0, 1);
    cycle(0, 1, 0);
    n = (9 - mm[0] + 60) % 60;
    repeat (n) cycle(0, 0, 1);
    cycle(0, 1, 0);
    repeat (59) cycle(1, 0, 0);
    check_val("a_120959", 32'({hour_a, min_a, sec_a}), 32'h120959);
    cycle(1, 0, 0);
    check_val("a_121000", 32'({hour_a, min_a, sec_a}), 32'h121000);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;
    repeat (5) cycle(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
